multimode_counter: RTL and testbench
====================================

// Module: multimode_counter
// PURPOSE
//   Parametrised synchronous counter; successor to the fixed 5-bit two-mode counter.
//   Adds:
//   - configurable width and terminal value;
//   - up, down, ping-pong and hold modes;
//   - synchronous load, clock-enable prescaler and a terminal-count pulse.
//   Used as a timebase/sequence generator in control datapaths.
// PARAMETERS
//   WIDTH    5             counter width in bits, >=2
//   MAX_VAL  2**WIDTH-1    terminal value; legal range 1..2**WIDTH-1
//   DIV      1             prescaler ratio; counter steps once per DIV enabled clocks; DIV>=1
// PORTS
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset
//   en        in   1      count enable; low freezes counter and prescaler
//   mode      in   2      00 up, 01 down, 10 ping-pong, 11 hold
//   load      in   1      synchronous load strobe
//   load_val  in   WIDTH  value to load
//   counter   out  WIDTH  current count (registered)
//   dir       out  1      current direction, 0 up / 1 down (registered)
//   tc        out  1      terminal-count pulse, one clk wide (registered)
// BEHAVIOUR
//   Reset and clock
//   - One clock, clk.
//   - Reset is asynchronous, active-low: rst_n low immediately forces counter=0, dir=0,
//     tc=0 and prescaler=0, regardless of clk. Operation resumes on the first clk edge
//     after rst_n rises.
//   Prescaler and steps
//   - Prescaler counts enabled clocks 0..DIV-1; step=1 on the cycle it equals DIV-1,
//     after which it returns to 0.
//   - DIV=1: step=en every cycle.
//   Priority per edge: load > step > idle
//   - load=1: counter <= (load_val>MAX_VAL ? MAX_VAL : load_val); prescaler <= 0;
//     dir unchanged; tc <= 0. load acts even when en=0.
//   - step, mode 00: counter==MAX_VAL -> counter<=0, tc<=1; else +1. dir<=0.
//   - step, mode 01: counter==0 -> counter<=MAX_VAL, tc<=1; else -1. dir<=1.
//   - step, mode 10 (ping-pong), dir=0: counter==MAX_VAL -> counter<=MAX_VAL-1,
//     dir<=1, tc<=1; else +1.
//   - step, mode 10 (ping-pong), dir=1: counter==0 -> counter<=1, dir<=0, tc<=1; else -1.
//   - Ping-pong sequence for MAX_VAL=3: 0 1 2 3 2 1 0 1 ...; each endpoint is held
//     for one step only.
//   - step, mode 11: counter and dir hold; tc<=0.
//   - No step and no load: all state holds; tc<=0.
//   - tc is high exactly in the cycle where counter shows the post-wrap/turn value.
//   Mode and enable changes
//   - A mode change takes effect at the next step, starting from the current counter value.
//   - Entering ping-pong continues in the current dir.
//   - counter never exceeds MAX_VAL; no out-of-range state exists.
//   - en deassert mid-prescale keeps the partial prescaler count; counting resumes
//     where it stopped.
//   Arithmetic
//   - All arithmetic is WIDTH bits, unsigned; comparisons are against the constant MAX_VAL.
// STRUCTURE
//   - Shared header counter_defs.vh: `define MODE_UP 2'b00, MODE_DOWN 2'b01,
//     MODE_PINGPONG 2'b10, MODE_HOLD 2'b11; clog2 function.
//   - Sub-module tick_prescaler:
//     params DIV; ports clk, rst_n, en, clr, tick.
//     Prescaler width is clog2(DIV), minimum 1.
//     Instantiated once; clr is driven by load.
//   - Top holds the counter/dir/tc registers and next-state logic in one always block
//     with an async-reset sensitivity.
// TESTING (default instance; plus a second instance with WIDTH=4, MAX_VAL=9, DIV=3)
//   1. Reset mid-count:
//      rst_n=0 at non-edge time with counter=7 -> counter=0, dir=0, tc=0 before the next edge.
//   2. Up wrap:
//      mode=00, en=1 for 33 clks from 0 -> counter 31 then 0, tc high for that single cycle only.
//   3. Down wrap:
//      mode=01 from 0 -> next counter=31, tc=1, dir=1; then 30 with tc=0.
//   4. Ping-pong on the second instance:
//      -> 0,1..9,8..0,1, each value held 3 clks; tc at 8 and at 1; dir toggles there.
//   5. Load beats step:
//      load=1, load_val=20 on a step cycle -> counter=20, tc=0.
//      Second instance: load_val=15 -> counter=9 (saturated).
//   6. Hold and enable:
//      mode=11 for 10 clks -> counter constant.
//      en=0 after 2 of 3 prescale clks, then en=1 -> step occurs on the 1st re-enabled clk.

Source files
------------

// File: rtl/multimode_counter_pkg.sv
// Shared definitions for the multimode counter: mode encoding and a width helper
// used to size the prescaler.
package multimode_counter_pkg;

  typedef enum logic [1:0] {
    MODE_UP       = 2'b00,
    MODE_DOWN     = 2'b01,
    MODE_PINGPONG = 2'b10,
    MODE_HOLD     = 2'b11
  } mode_e;

  // Bits needed to hold 0..value-1, never less than one bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << w) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/multimode_counter_if.sv
// Control and status bundle of the multimode counter; the counter is the slave,
// whatever drives mode/enable/load is the master.
interface multimode_counter_if #(
  parameter int WIDTH = 5
);

  logic             en;
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] counter;
  logic             dir;
  logic             tc;

  modport master (
    output en, mode, load, load_val,
    input  counter, dir, tc
  );

  modport slave (
    input  en, mode, load, load_val,
    output counter, dir, tc
  );

endinterface

// File: rtl/multimode_counter_tick_prescaler.sv
// Clock-enable prescaler: emits one tick per DIV enabled clocks and keeps its
// partial count while en is low.
module multimode_counter_tick_prescaler
  import multimode_counter_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int             PW   = clog2_min1(DIV);
  localparam logic [PW-1:0]  LAST = PW'(DIV - 1);

  logic [PW-1:0] r_cnt;

  // With DIV=1 LAST is zero, so tick simply follows en.
  assign tick = en && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr || tick) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/multimode_counter.sv
// Parametrised up/down/ping-pong/hold counter with saturating synchronous load,
// prescaled stepping and a registered terminal-count pulse.
module multimode_counter
  import multimode_counter_pkg::*;
#(
  parameter int WIDTH   = 5,
  parameter int MAX_VAL = (1 << WIDTH) - 1,
  parameter int DIV     = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  multimode_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);

  logic             w_step;
  logic [WIDTH-1:0] r_counter;
  logic             r_dir;
  logic             r_tc;

  function automatic logic [WIDTH-1:0] sat_load(input logic [WIDTH-1:0] value);
    return (value > MAX) ? MAX : value;
  endfunction

  // Load also restarts the prescaler so the first step after a load is a full period away.
  multimode_counter_tick_prescaler #(
    .DIV (DIV)
  ) u_tick_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.en),
    .clr   (bus.load),
    .tick  (w_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_counter <= '0;
      r_dir     <= 1'b0;
      r_tc      <= 1'b0;
    end else if (bus.load) begin
      r_counter <= sat_load(bus.load_val);
      r_tc      <= 1'b0;
    end else if (w_step) begin
      r_tc <= 1'b0;
      case (mode_e'(bus.mode))
        MODE_UP: begin
          r_dir <= 1'b0;
          if (r_counter == MAX) begin
            r_counter <= '0;
            r_tc      <= 1'b1;
          end else begin
            r_counter <= r_counter + 1'b1;
          end
        end
        MODE_DOWN: begin
          r_dir <= 1'b1;
          if (r_counter == '0) begin
            r_counter <= MAX;
            r_tc      <= 1'b1;
          end else begin
            r_counter <= r_counter - 1'b1;
          end
        end
        // Turn-around steps straight off the endpoint so it is shown for one step only.
        MODE_PINGPONG: begin
          if (!r_dir) begin
            if (r_counter == MAX) begin
              r_counter <= MAX - 1'b1;
              r_dir     <= 1'b1;
              r_tc      <= 1'b1;
            end else begin
              r_counter <= r_counter + 1'b1;
            end
          end else begin
            if (r_counter == '0) begin
              r_counter <= WIDTH'(1);
              r_dir     <= 1'b0;
              r_tc      <= 1'b1;
            end else begin
              r_counter <= r_counter - 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end else begin
      r_tc <= 1'b0;
    end
  end

  assign bus.counter = r_counter;
  assign bus.dir     = r_dir;
  assign bus.tc      = r_tc;

endmodule

// File: tb/tb_multimode_counter.sv
// Bench for multimode_counter: a default instance and a WIDTH=4/MAX_VAL=9/DIV=3
// instance, checked against directed expectations and a behavioural model.
module tb_multimode_counter;

  localparam int WA = 5;
  localparam int MA = 31;
  localparam int DA = 1;
  localparam int WB = 4;
  localparam int MB = 9;
  localparam int DB = 3;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  multimode_counter_if #(.WIDTH(WA)) ifa ();
  multimode_counter_if #(.WIDTH(WB)) ifb ();

  multimode_counter #(.WIDTH(WA)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  multimode_counter #(.WIDTH(WB), .MAX_VAL(MB), .DIV(DB)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  typedef struct {
    int cnt;
    int dir;
    int tc;
    int pre;
  } mdl_t;

  mdl_t ma, mb;
  int   vectors = 0;
  int   miscompares = 0;

  // Behavioural reference: one call per rising clock edge.
  function automatic mdl_t nxt(mdl_t m, int maxv, int div, bit en, int mode, bit load, int lv);
    mdl_t r;
    r    = m;
    r.tc = 0;
    if (load) begin
      r.cnt = (lv > maxv) ? maxv : lv;
      r.pre = 0;
      return r;
    end
    if (!en) return r;
    if (m.pre < div - 1) begin
      r.pre = m.pre + 1;
      return r;
    end
    r.pre = 0;
    case (mode)
      0: begin
        r.dir = 0;
        r.cnt = (m.cnt == maxv) ? 0 : m.cnt + 1;
        r.tc  = (m.cnt == maxv) ? 1 : 0;
      end
      1: begin
        r.dir = 1;
        r.cnt = (m.cnt == 0) ? maxv : m.cnt - 1;
        r.tc  = (m.cnt == 0) ? 1 : 0;
      end
      2: begin
        if (m.dir == 0 && m.cnt == maxv) begin
          r.cnt = maxv - 1; r.dir = 1; r.tc = 1;
        end else if (m.dir == 1 && m.cnt == 0) begin
          r.cnt = 1; r.dir = 0; r.tc = 1;
        end else begin
          r.cnt = (m.dir == 0) ? m.cnt + 1 : m.cnt - 1;
        end
      end
      default: begin
      end
    endcase
    return r;
  endfunction

  task automatic idle_inputs();
    ifa.en = 1'b0; ifa.mode = 2'd0; ifa.load = 1'b0; ifa.load_val = '0;
    ifb.en = 1'b0; ifb.mode = 2'd0; ifb.load = 1'b0; ifb.load_val = '0;
  endtask

  task automatic clk_model();
    @(posedge clk);
    ma = nxt(ma, MA, DA, ifa.en, int'(ifa.mode), ifa.load, int'(ifa.load_val));
    mb = nxt(mb, MB, DB, ifb.en, int'(ifb.mode), ifb.load, int'(ifb.load_val));
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    ma = '{0, 0, 0, 0};
    mb = '{0, 0, 0, 0};
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({ifa.counter, ifa.dir, ifa.tc} !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_a: got %b want 0000000", {ifa.counter, ifa.dir, ifa.tc});
    end
    vectors++;
    if ({ifb.counter, ifb.dir, ifb.tc} !== 6'd0) begin
      miscompares++;
      $display("FAIL reset_b: got %b want 000000", {ifb.counter, ifb.dir, ifb.tc});
    end
    ma = '{0, 0, 0, 0};
    mb = '{0, 0, 0, 0};
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_count();
    apply_reset();
    ifa.en = 1'b1;
    repeat (7) clk_model();
    vectors++;
    if (ifa.counter !== 5'd7) begin
      miscompares++;
      $display("FAIL reset_mid_pre: got %0d want 7", ifa.counter);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({ifa.counter, ifa.dir, ifa.tc} !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_mid_async: got %b want 0000000", {ifa.counter, ifa.dir, ifa.tc});
    end
    ma = '{0, 0, 0, 0};
    mb = '{0, 0, 0, 0};
    idle_inputs();
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_up_wrap();
    apply_reset();
    ifa.en = 1'b1; ifa.mode = 2'b00;
    for (int c = 1; c <= 33; c++) begin
      clk_model();
      vectors++;
      if (ifa.counter !== WA'(c % 32) || ifa.tc !== (c == 32)) begin
        miscompares++;
        $display("FAIL up_wrap clk %0d: got cnt=%0d tc=%b want cnt=%0d tc=%b",
                 c, ifa.counter, ifa.tc, c % 32, (c == 32));
      end
    end
  endtask

  task automatic test_down_wrap();
    apply_reset();
    ifa.en = 1'b1; ifa.mode = 2'b01;
    clk_model();
    vectors++;
    if ({ifa.counter, ifa.dir, ifa.tc} !== {5'd31, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL down_wrap: got cnt=%0d dir=%b tc=%b want 31 1 1", ifa.counter, ifa.dir, ifa.tc);
    end
    clk_model();
    vectors++;
    if ({ifa.counter, ifa.dir, ifa.tc} !== {5'd30, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL down_next: got cnt=%0d dir=%b tc=%b want 30 1 0", ifa.counter, ifa.dir, ifa.tc);
    end
  endtask

  task automatic test_pingpong();
    int pp[$];
    int idx;
    bit etc, edir;
    for (int v = 0; v <= MB; v++) pp.push_back(v);
    for (int v = MB - 1; v >= 0; v--) pp.push_back(v);
    pp.push_back(1);
    apply_reset();
    ifb.en = 1'b1; ifb.mode = 2'b10;
    for (int c = 1; c < 3 * pp.size(); c++) begin
      clk_model();
      idx  = c / 3;
      etc  = (c % 3 == 0) && (idx == MB + 1 || idx == 2 * MB + 1);
      edir = (idx >= MB + 1) && (idx <= 2 * MB);
      vectors++;
      if (ifb.counter !== WB'(pp[idx]) || ifb.tc !== etc || ifb.dir !== edir) begin
        miscompares++;
        $display("FAIL pingpong clk %0d: got cnt=%0d dir=%b tc=%b want cnt=%0d dir=%b tc=%b",
                 c, ifb.counter, ifb.dir, ifb.tc, pp[idx], edir, etc);
      end
    end
  endtask

  task automatic test_load();
    apply_reset();
    ifa.en = 1'b1; ifa.mode = 2'b00; ifa.load = 1'b1; ifa.load_val = 5'd31;
    clk_model();
    ifa.load_val = 5'd20;
    clk_model();
    vectors++;
    if ({ifa.counter, ifa.tc} !== {5'd20, 1'b0}) begin
      miscompares++;
      $display("FAIL load_beats_wrap: got cnt=%0d tc=%b want 20 0", ifa.counter, ifa.tc);
    end
    ifa.load = 1'b0;
    clk_model();
    vectors++;
    if (ifa.counter !== 5'd21) begin
      miscompares++;
      $display("FAIL load_then_step: got %0d want 21", ifa.counter);
    end
    ifb.en = 1'b0; ifb.load = 1'b1; ifb.load_val = 4'd15;
    clk_model();
    vectors++;
    if ({ifb.counter, ifb.tc} !== {4'd9, 1'b0}) begin
      miscompares++;
      $display("FAIL load_saturate: got cnt=%0d tc=%b want 9 0", ifb.counter, ifb.tc);
    end
    ifb.en = 1'b1; ifb.load_val = 4'd5;
    clk_model();
    ifb.load = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      clk_model();
      vectors++;
      if (ifb.counter !== ((c < 3) ? 4'd5 : 4'd6)) begin
        miscompares++;
        $display("FAIL load_clr_prescale clk %0d: got %0d want %0d", c, ifb.counter, (c < 3) ? 5 : 6);
      end
    end
  endtask

  task automatic test_hold_enable();
    apply_reset();
    ifa.load = 1'b1; ifa.load_val = 5'd17;
    clk_model();
    ifa.load = 1'b0; ifa.en = 1'b1; ifa.mode = 2'b11;
    for (int c = 1; c <= 10; c++) begin
      clk_model();
      vectors++;
      if ({ifa.counter, ifa.tc} !== {5'd17, 1'b0}) begin
        miscompares++;
        $display("FAIL hold clk %0d: got cnt=%0d tc=%b want 17 0", c, ifa.counter, ifa.tc);
      end
    end
    apply_reset();
    ifb.en = 1'b1; ifb.mode = 2'b00;
    repeat (2) clk_model();
    ifb.en = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      clk_model();
      vectors++;
      if (ifb.counter !== 4'd0) begin
        miscompares++;
        $display("FAIL en_low clk %0d: got %0d want 0", c, ifb.counter);
      end
    end
    ifb.en = 1'b1;
    clk_model();
    vectors++;
    if ({ifb.counter, ifb.tc} !== {4'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL en_resume: got cnt=%0d tc=%b want 1 0", ifb.counter, ifb.tc);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      ifa.en       = ($urandom_range(0, 7) != 0);
      ifa.mode     = 2'($urandom_range(0, 3));
      ifa.load     = ($urandom_range(0, 15) == 0);
      ifa.load_val = WA'($urandom);
      ifb.en       = ($urandom_range(0, 7) != 0);
      ifb.mode     = 2'($urandom_range(0, 3));
      ifb.load     = ($urandom_range(0, 15) == 0);
      ifb.load_val = WB'($urandom);
      clk_model();
      vectors++;
      if ({ifa.counter, ifa.dir, ifa.tc} !== {WA'(ma.cnt), 1'(ma.dir), 1'(ma.tc)}) begin
        miscompares++;
        $display("FAIL random_a step %0d: got cnt=%0d dir=%b tc=%b want cnt=%0d dir=%0d tc=%0d",
                 i, ifa.counter, ifa.dir, ifa.tc, ma.cnt, ma.dir, ma.tc);
      end
      vectors++;
      if ({ifb.counter, ifb.dir, ifb.tc} !== {WB'(mb.cnt), 1'(mb.dir), 1'(mb.tc)}) begin
        miscompares++;
        $display("FAIL random_b step %0d: got cnt=%0d dir=%b tc=%b want cnt=%0d dir=%0d tc=%0d",
                 i, ifb.counter, ifb.dir, ifb.tc, mb.cnt, mb.dir, mb.tc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_count();
    test_up_wrap();
    test_down_wrap();
    test_pingpong();
    test_load();
    test_hold_enable();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
